// File: rtl/lfsr_encryptor.sv
// Streaming LFSR encrypter: builds a fixed 64-byte frame of preamble, message and post-pad,
// each byte (char - 0x20) XOR the 7-bit LFSR state, with even parity in bit 7.
module lfsr_encryptor #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned MSG_MAX   = 52,
  parameter int unsigned PRE_MIN   = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] pre_length,
  input  logic [6:0] lfsr_taps,
  input  logic [6:0] lfsr_init,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [5:0] out_index,
  input  logic       out_ready,
  output logic       Ack
);

  localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);
  localparam logic [5:0] MSG_MAX_L = 6'(MSG_MAX);
  localparam logic [3:0] PRE_MIN_L = 4'(PRE_MIN);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    MSG,
    POST,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] taps_q;
  logic [6:0] lfsr_q;
  logic [3:0] pre_q;
  logic [5:0] idx_q;
  logic       full_q;
  logic [5:0] msg_cnt_q;

  logic       slot_free;
  logic       load;
  logic       launch;
  logic [6:0] plain;
  logic [6:0] cipher;
  logic [5:0] pre_last;

  assign slot_free = !out_valid || out_ready;
  assign launch    = (state_q == IDLE || state_q == DONE) && Start;
  assign pre_last  = 6'(pre_q) - 6'd1;
  assign cipher    = plain ^ lfsr_q;
  assign Ack       = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    plain    = '0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: if (Start) state_d = PRE;
      PRE: begin
        if (slot_free && !full_q) begin
          load = 1'b1;
          if (idx_q == pre_last) state_d = MSG;
        end
      end
      MSG: begin
        if (slot_free && !full_q && msg_cnt_q < MSG_MAX_L) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load  = 1'b1;
            plain = 7'(in_data - 8'h20);
            if (in_last || msg_cnt_q == MSG_MAX_L - 6'd1) state_d = POST;
          end
        end
      end
      POST: if (slot_free && !full_q) load = 1'b1;
      DONE: if (Start) state_d = PRE;
      default: state_d = IDLE;
    endcase
    // Byte 63 already loaded: the frame closes when it leaves the output register,
    // whichever phase we are in (a long message can fill the frame from MSG).
    if ((state_q == PRE || state_q == MSG || state_q == POST) && full_q && out_valid && out_ready)
      state_d = DONE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      taps_q    <= '0;
      lfsr_q    <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      full_q    <= 1'b0;
      msg_cnt_q <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        taps_q    <= lfsr_taps;
        lfsr_q    <= (lfsr_init == '0) ? 7'h01 : lfsr_init;
        pre_q     <= (pre_length < PRE_MIN_L) ? PRE_MIN_L : pre_length;
        idx_q     <= '0;
        full_q    <= 1'b0;
        msg_cnt_q <= '0;
      end else if (load) begin
        lfsr_q <= {lfsr_q[5:0], ^(lfsr_q & taps_q)};
        idx_q  <= idx_q + 6'd1;
        full_q <= (idx_q == LAST_IDX);
        if (state_q == MSG) msg_cnt_q <= msg_cnt_q + 6'd1;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= {^cipher, cipher};
        out_index <= idx_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lfsr_encryptor.md
Name: lfsr_encryptor

Overview:
- Hardware encrypter for the message-cipher datapath; it is the transmit-side counterpart of the Program 2 decrypt flow.
- Consumes an ASCII character stream and produces a fixed 64-byte encrypted frame: preamble, then message, then post-pad.
- Each byte is (char - 0x20) XOR the current 7-bit LFSR state, with even parity of bits [6:0] placed in bit 7.
- Sits between a message source and data memory or a downstream decrypter, which it feeds as test stimulus.

Parameters:
- FRAME_LEN, 64, output bytes per frame.
- MSG_MAX, 52, maximum message characters consumed per frame.
- PRE_MIN, 10, minimum preamble length; smaller requests are raised to this value.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  launches a frame; sampled only in IDLE or DONE.
- pre_length  input  4  requested preamble byte count; latched at Start.
- lfsr_taps  input  7  feedback tap mask; latched at Start.
- lfsr_init  input  7  LFSR seed; latched at Start; 0 is replaced by 7'h01.
- in_valid  input  1  message character available.
- in_data  input  8  ASCII character, 0x20..0x9F.
- in_last  input  1  marks in_data as the final message character.
- in_ready  output  1  character accepted when in_valid && in_ready.
- out_valid  output  1  encrypted byte held in out_data.
- out_data  output  8  {parity, cipher[6:0]}.
- out_index  output  6  frame position of out_data, 0..63.
- out_ready  input  1  consumer takes the byte when out_valid && out_ready.
- Ack  output  1  frame complete; level signal.

Behaviour:
- Reset (any state, including mid-frame): state=IDLE, out_valid=0, out_data=0, out_index=0, in_ready=0, Ack=0, internal counters=0. A partially emitted frame is abandoned.
- States: IDLE, PRE, MSG, POST, DONE.
- IDLE/DONE with Start=1:
  - Latch taps and seed (seed 0 becomes 1).
  - Latch pre = max(pre_length, PRE_MIN).
  - Clear byte index and message count; clear Ack; go to PRE.
  - In DONE without Start: hold, Ack=1.
- LFSR advance: next = {state[5:0], ^(state & taps)}. It advances exactly once per byte loaded into the output register; the byte at index i uses LFSR state i, where state 0 is the seed.
- Output register:
  - A new byte may be loaded when the slot is free: !out_valid || out_ready.
  - out_valid is set on load and cleared when the byte is consumed and no new load occurs in the same cycle.
  - Throughput is one byte per cycle when out_ready is held high.
  - out_data and out_index are stable while out_valid && !out_ready.
- PRE: loads plaintext 0x00 (a space minus 0x20) at indices 0..pre-1, then moves to MSG.
- MSG:
  - in_ready = slot free.
  - On accept, loads plaintext (in_data - 0x20)[6:0] and increments the message count.
  - When no character is valid, nothing is loaded and the LFSR does not advance.
  - Leaves to POST after accepting in_last, or after the MSG_MAX-th character. Characters beyond 52 stay unconsumed (in_ready=0).
- POST: loads plaintext 0x00 until index 63 has been loaded.
- Frame end: in any state, once index 63 is loaded, no further loads occur. This applies even in MSG (pre + message > 64); remaining input stays unconsumed. When byte 63 is consumed, go to DONE and assert Ack the following cycle.
- Cipher: c = plain ^ lfsr; out_data = {^c[6:0], c[6:0]}.
- in_ready=0 in all states except MSG.
- Start asserted while in PRE, MSG or POST is ignored.

Test Plan:
- Reset, then Start with taps=0x72, seed=0x01, pre_length=10, out_ready=1 -> indices 0,1,2 emit 0x81, 0x82, 0x05; in_ready stays 0 through index 9.
- Stream "Mr. Watson, come here. I want to see you." (41 chars, in_last on the final '.'), pre=10, random seed, taps=0x72 -> 64 bytes total; index 10 equals (0x2D ^ lfsr[10]) with correct parity; indices 51..63 use plaintext 0; Ack=1 after byte 63 is consumed. Cross-check all 64 bytes against a software model.
- pre_length=3 -> treated as 10: first message byte at index 10.
- pre_length=15 with a 60-char source -> exactly 49 chars consumed (indices 15..63); in_ready=0 after that; Ack rises.
- seed=0 -> behaves identically to seed=0x01.
- Randomized out_ready and in_valid gaps -> out_data/out_index held while stalled; no byte lost or duplicated; LFSR sequence unchanged versus the no-stall run. Reset asserted at index 30 -> out_valid=0 and Ack=0 the next cycle; a new Start produces a correct full frame.
